// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// freq_meter -- counts synchronized sig_in rising edges per gate window | rev 1.0
// ============================================================================
module freq_meter #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int               GW       = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_END = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat_flag;
  logic             sync1;
  logic             sync2;
  logic             sync_dly;
  logic             edge_p;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  logic unused_clk_freq;
  assign unused_clk_freq = (CLK_FREQ != 0);

  // Synchronizer and edge detector run in every state so entering GATE never
  // sees a stale level as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_dly <= 1'b0;
      edge_p   <= 1'b0;
    end else begin
      sync1    <= sig_in;
      sync2    <= sync1;
      sync_dly <= sync2;
      edge_p   <= sync2 & ~sync_dly;
    end
  end

  always_comb begin
    cnt_nxt = edge_cnt;
    sat_nxt = sat_flag;
    if (edge_p) begin
      if (edge_cnt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        cnt_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  // Result is loaded on the GATE->LATCH edge so freq/ovf are already new
  // while valid is high during the LATCH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_flag <= 1'b0;
          if (en) begin
            state <= GATE;
          end
        end
        GATE: begin
          if (!en) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
          end else if (gate_cnt == GATE_END) begin
            state    <= LATCH;
            freq     <= cnt_nxt;
            ovf      <= sat_nxt;
            valid    <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= cnt_nxt;
            sat_flag <= sat_nxt;
          end
        end
        LATCH: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_flag <= 1'b0;
          state    <= en ? GATE : IDLE;
        end
        default: begin
          state    <= IDLE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_flag <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == GATE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// tb_freq_meter -- directed + randomized checks against a window-count reference model
module tb_freq_meter;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic [31:0] freq32;
  logic        valid32, ovf32, busy32;
  logic [3:0]  freq4;
  logic        valid4, ovf4, busy4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  freq_meter #(.CLK_FREQ(1000), .GATE_CYCLES(G), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq32), .valid(valid32), .ovf(ovf32), .busy(busy32)
  );

  freq_meter #(.CLK_FREQ(1000), .GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq4), .valid(valid4), .ovf(ovf4), .busy(busy4)
  );

  // Reference model: every rising transition of the clock-sampled input is
  // due to be counted 3 clock edges after it was sampled.
  int cyc = 0;
  bit prev = 1'b0;
  int edges[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev = 1'b0;
      edges.delete();
    end else begin
      if (sig_in && !prev) edges.push_back(cyc + 3);
      prev = sig_in;
    end
    while (edges.size() > 0 && edges[0] < cyc - 400) void'(edges.pop_front());
  end

  function automatic int count_in(input int lo, input int hi);
    int n = 0;
    foreach (edges[i]) if (edges[i] >= lo && edges[i] <= hi) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (valid32 === 1'b1) break;
    end
    chk({tag, "_valid"}, {31'b0, valid32}, 32'd1);
  endtask

  // The window is the G counting edges ending at the edge that raised valid.
  task automatic check_window(input string tag, output int n);
    n = count_in(cyc - G + 1, cyc);
    chk({tag, "_freq32"}, freq32, 32'(n));
    chk({tag, "_ovf32"}, {31'b0, ovf32}, 32'd0);
    chk({tag, "_freq4"}, {28'b0, freq4}, (n > 15) ? 32'd15 : 32'(n));
    chk({tag, "_ovf4"}, {31'b0, ovf4}, (n > 15) ? 32'd1 : 32'd0);
    chk({tag, "_valid4"}, {31'b0, valid4}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy32}, 32'd0);
  endtask

  int half = 0;
  bit rnd = 1'b0;
  int ph = 0;

  initial begin
    int n, last, e0, nv;
    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rnd) sig_in = 1'($urandom_range(0, 1));
        else if (half > 0) begin
          ph++;
          if (ph >= half) begin
            ph = 0;
            sig_in = ~sig_in;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_freq", freq32, 32'd0);
    chk("rst_valid", {31'b0, valid32}, 32'd0);
    chk("rst_ovf", {31'b0, ovf32}, 32'd0);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_freq4", {28'b0, freq4}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Square wave, period 10: steady windows of 10 edges every G+1 cycles
    half = 5; ph = 0;
    @(negedge clk) en = 1'b1;
    wait_valid(G + 10, "sq_first");
    check_window("sq_first", n);
    last = cyc;
    for (int w = 0; w < 3; w++) begin
      wait_valid(G + 5, "sq");
      chk("sq_period", 32'(cyc - last), 32'(G + 1));
      last = cyc;
      check_window("sq", n);
      chk("sq_freq10", freq32, 32'd10);
    end

    // Reset during gate cycle 60
    repeat (61) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_freq", freq32, 32'd0);
    chk("midrst_valid", {31'b0, valid32}, 32'd0);
    chk("midrst_busy", {31'b0, busy32}, 32'd0);
    chk("midrst_ovf", {31'b0, ovf32}, 32'd0);
    @(negedge clk) rst = 1'b0;
    wait_valid(G + 10, "postrst");
    check_window("postrst", n);

    // Abort at gate cycle 50
    repeat (51) @(negedge clk);
    chk("abort_busy_before", {31'b0, busy32}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", {31'b0, busy32}, 32'd0);
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid32 === 1'b1) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    chk("abort_freq_held", freq32, 32'(n));

    // sig_in already high before en
    half = 0;
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_valid(G + 10, "level");
    check_window("level", n);
    chk("level_freq0", freq32, 32'd0);
    en = 1'b0;

    // Saturation on the 4-bit counter: period 4
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    half = 2; ph = 0;
    repeat (8) @(negedge clk);
    en = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 95) @(negedge clk);
    half = 0;
    sig_in = 1'b0;
    wait_valid(G + 10, "sat");
    check_window("sat", n);
    chk("sat_freq4", {28'b0, freq4}, 32'd15);
    chk("sat_ovf4", {31'b0, ovf4}, 32'd1);
    wait_valid(G + 5, "unsat");
    check_window("unsat", n);
    chk("unsat_freq4", {28'b0, freq4}, 32'd0);
    chk("unsat_ovf4", {31'b0, ovf4}, 32'd0);
    en = 1'b0;

    // Single edge on the final gate cycle, then one in the LATCH cycle
    repeat (5) @(negedge clk);
    en = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 96) @(negedge clk);
    sig_in = 1'b1;
    @(negedge clk) sig_in = 1'b0;
    wait_valid(G + 10, "lastcyc");
    chk("lastcyc_time", 32'(cyc), 32'(e0 + G));
    check_window("lastcyc", n);
    chk("lastcyc_freq1", freq32, 32'd1);
    while (cyc < e0 + 198) @(negedge clk);
    sig_in = 1'b1;
    @(negedge clk) sig_in = 1'b0;
    wait_valid(G + 5, "dead_a");
    check_window("dead_a", n);
    chk("dead_a_freq0", freq32, 32'd0);
    wait_valid(G + 5, "dead_b");
    check_window("dead_b", n);
    chk("dead_b_freq0", freq32, 32'd0);

    // Randomized windows
    for (int w = 0; w < 6; w++) begin
      if ($urandom_range(0, 2) == 0) begin
        half = 0;
        rnd = 1'b1;
      end else begin
        rnd = 1'b0;
        half = int'($urandom_range(1, 9));
      end
      wait_valid(G + 5, "rand");
      check_window("rand", n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz, documentation only.
REQ-002 SHALL have parameter GATE_CYCLES, default 50_000_000: gate window length in clk cycles (1 s at 50 MHz); minimum 2.
REQ-003 SHALL have parameter CNT_W, default 32: width of the edge counter and the result.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: measurement enable; level-sensitive.
REQ-007 SHALL have port sig_in, input, 1 bit: asynchronous external signal to measure.
REQ-008 SHALL have port freq, output, CNT_W bits: rising edges counted in the last completed gate window.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when freq is updated.
REQ-010 SHALL have port ovf, output, 1 bit: the last completed window saturated the counter.
REQ-011 SHALL have port busy, output, 1 bit: high while a gate window is open.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer, then a delay flop; an edge SHALL be detected when sync=1 and the delayed value=0.
REQ-013 SHALL run the synchronizer and edge flops in every state, so no spurious edge occurs on entry to GATE.
REQ-014 SHALL register the edge pulse, so a sig_in transition is counted 3-4 clk cycles after it occurs.
REQ-015 SHALL implement states IDLE, GATE and LATCH.
REQ-016 IDLE: gate_cnt=0 and edge_cnt=0; when en=1, SHALL move to GATE on the next cycle.
REQ-017 GATE: SHALL increment gate_cnt every cycle and increment edge_cnt on every detected edge, including the final gate cycle.
REQ-018 GATE: when gate_cnt==GATE_CYCLES-1 and en=1, SHALL move to LATCH; the window is exactly GATE_CYCLES cycles.
REQ-019 GATE: when en=0, SHALL abort to IDLE; freq, ovf and valid SHALL be unchanged and no valid pulse SHALL occur.
REQ-020 LATCH (one cycle): SHALL set freq<=edge_cnt, ovf<=sat_flag and valid=1, clear both counters and sat_flag, then go to GATE if en=1, else IDLE.
REQ-021 SHALL ignore edges arriving during the LATCH cycle (dead time of 1 cycle per window).
REQ-022 SHALL saturate edge_cnt at 2^CNT_W-1; an edge arriving at saturation SHALL set sat_flag, which stays set until LATCH.
REQ-023 SHALL hold freq and ovf between LATCH cycles, with valid=0 outside LATCH.
REQ-024 busy SHALL equal (state==GATE).
REQ-025 SHALL size gate_cnt to $clog2(GATE_CYCLES) bits, and gate_cnt SHALL never exceed GATE_CYCLES-1.

Reset
REQ-026 When rst=1, at any time and in any state, SHALL immediately put state=IDLE and freq=0, valid=0, ovf=0, busy=0.
REQ-027 When rst=1, SHALL clear all counters, sat_flag and all synchronizer/edge flops to 0.
REQ-028 After rst is released, SHALL require no more than one clk edge before it responds to en.
REQ-029 When reset occurs mid-GATE, SHALL discard the partial window and SHALL NOT issue a valid pulse.

Verification (GATE_CYCLES=100, CNT_W=32 unless noted)
REQ-030 Scenario: en=1 held, sig_in square wave with period 10 cycles -> valid pulses every 101 cycles, each with freq=10, ovf=0.
REQ-031 Scenario: en=1, sig_in held at 1 from before en rises -> freq=0 at first valid (no spurious edge).
REQ-032 Scenario: CNT_W=4, sig_in period 4 cycles (25 edges) -> freq=15, ovf=1; next window with sig_in=0 -> freq=0, ovf=0.
REQ-033 Scenario: en dropped at gate cycle 50 -> busy falls next cycle, no valid pulse, freq retains previous value.
REQ-034 Scenario: rst pulsed at gate cycle 60 with freq=10 held -> freq=0, valid=0, busy=0 immediately; a fresh window then yields the correct count.
REQ-035 Scenario: single sig_in pulse placed so the edge is detected on gate cycle 99 -> counted (freq=1); edge detected in the LATCH cycle -> not counted in either window.
